// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data (load/store)
// port share one synchronous single-port memory. Grants are combinational,
// contention is resolved round-robin, read data returns one cycle after the
// grant, and each port keeps a saturating grant counter.
module mem_arbiter #(
   parameter int AW = 8,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   // instruction-fetch port
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_gnt,
   output logic          i_rvalid,
   output logic [31:0]   i_rdata,
   // data port
   input  logic          d_req,
   input  logic          d_we,
   input  logic [3:0]    d_wmask,
   input  logic [AW-1:0] d_addr,
   input  logic [31:0]   d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [31:0]   d_rdata,
   // memory side
   output logic          mem_en,
   output logic [3:0]    mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   // grant counters
   output logic [CW-1:0] i_cnt,
   output logic [CW-1:0] d_cnt
);

   localparam logic          OWNER_I = 1'b0;
   localparam logic          OWNER_D = 1'b1;
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

   logic last_owner_r;   // port granted most recently
   logic rd_pend_r;      // a read was granted in the previous cycle
   logic rd_owner_r;     // which port that read belongs to

   // Saturating increment: the counter sticks at its maximum instead of wrapping.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] value);
      if (value == CNT_MAX) begin
         return value;
      end else begin
         return value + CNT_ONE;
      end
   endfunction

   // Grant selection: a lone requester wins outright; on contention the port
   // that did not win last time is granted. Reset forces both grants low.
   always_comb begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
      if (!reset) begin
         i_gnt = 1'b0;
         d_gnt = 1'b0;
      end else if (i_req && d_req) begin
         if (last_owner_r == OWNER_I) begin
            d_gnt = 1'b1;
         end else begin
            i_gnt = 1'b1;
         end
      end else if (i_req) begin
         i_gnt = 1'b1;
      end else if (d_req) begin
         d_gnt = 1'b1;
      end else begin
         i_gnt = 1'b0;
         d_gnt = 1'b0;
      end
   end

   // Memory port mux: steer the granted port's address/data to the memory;
   // fetches never write, and stores write only the enabled bytes.
   always_comb begin
      mem_en    = i_gnt | d_gnt;
      mem_we    = 4'b0000;
      mem_addr  = {AW{1'b0}};
      mem_wdata = 32'h0000_0000;
      if (d_gnt) begin
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         mem_we    = d_we ? d_wmask : 4'b0000;
      end else if (i_gnt) begin
         mem_addr  = i_addr;
      end else begin
         mem_addr  = {AW{1'b0}};
      end
   end

   // Round-robin history: remember which port won the latest grant.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_owner_r <= OWNER_I;
      end else if (i_gnt) begin
         last_owner_r <= OWNER_I;
      end else if (d_gnt) begin
         last_owner_r <= OWNER_D;
      end else begin
         last_owner_r <= last_owner_r;
      end
   end

   // Read pipeline: any fetch or load grant returns data one cycle later;
   // stores (including a zero-mask store) produce no response.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_pend_r  <= 1'b0;
         rd_owner_r <= OWNER_I;
      end else begin
         rd_pend_r  <= i_gnt | (d_gnt & ~d_we);
         rd_owner_r <= d_gnt ? OWNER_D : OWNER_I;
      end
   end

   // Grant counters, one per port, saturating at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         i_cnt <= {CW{1'b0}};
         d_cnt <= {CW{1'b0}};
      end else begin
         i_cnt <= i_gnt ? sat_inc(i_cnt) : i_cnt;
         d_cnt <= d_gnt ? sat_inc(d_cnt) : d_cnt;
      end
   end

   // Response routing: only the owning port sees rvalid, and read data is
   // forced to zero whenever its rvalid is low.
   always_comb begin
      i_rvalid = rd_pend_r & (rd_owner_r == OWNER_I);
      d_rvalid = rd_pend_r & (rd_owner_r == OWNER_D);
      i_rdata  = 32'h0000_0000;
      d_rdata  = 32'h0000_0000;
      if (i_rvalid) begin
         i_rdata = mem_rdata;
      end else if (d_rvalid) begin
         d_rdata = mem_rdata;
      end else begin
         i_rdata = 32'h0000_0000;
         d_rdata = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural memory, a reference
// model of the arbitration rules, and a scoreboard of expected read responses
// consumed by an independent monitor.
module tb_mem_arbiter;

   localparam int AW = 8;
   localparam int CW = 16;

   typedef struct packed {
      logic [31:0] cyc;
      logic [31:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [AW-1:0] i_addr = '0, d_addr = '0;
   logic [3:0]    d_wmask = 4'h0;
   logic [31:0]   d_wdata = 32'h0;
   logic          i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en;
   logic [31:0]   i_rdata, d_rdata, mem_wdata;
   logic [31:0]   mem_rdata = 32'h0;
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_addr;
   logic [CW-1:0] i_cnt, d_cnt;

   // second instance with a 2-bit counter for saturation
   logic          i_req2 = 1'b0;
   logic          i_gnt2, i_rvalid2, d_gnt2, d_rvalid2, mem_en2;
   logic [31:0]   i_rdata2, d_rdata2, mem_wdata2;
   logic [3:0]    mem_we2;
   logic [AW-1:0] mem_addr2;
   logic [1:0]    i_cnt2, d_cnt2;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t iq[$];
   exp_t dq[$];
   logic [31:0] ref_mem [0:(1<<AW)-1];
   logic [31:0] mem_env [0:(1<<AW)-1];
   int   ni = 0, nd = 0;     // grants issued per port
   bit   last_d = 1'b0;      // data port won most recently

   mem_arbiter #(.AW(AW), .CW(CW)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .i_cnt(i_cnt), .d_cnt(d_cnt)
   );

   mem_arbiter #(.AW(AW), .CW(2)) dut2 (
      .clk(clk), .reset(reset),
      .i_req(i_req2), .i_addr(8'h00), .i_gnt(i_gnt2), .i_rvalid(i_rvalid2), .i_rdata(i_rdata2),
      .d_req(1'b0), .d_we(1'b0), .d_wmask(4'h0), .d_addr(8'h00), .d_wdata(32'h0),
      .d_gnt(d_gnt2), .d_rvalid(d_rvalid2), .d_rdata(d_rdata2),
      .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
      .mem_rdata(32'h0), .i_cnt(i_cnt2), .d_cnt(d_cnt2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(input int a);
      if (a == 5) return 32'h0000_0013;
      if (a == 7) return 32'h1122_3344;
      return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Behavioural synchronous memory: byte writes, read data one cycle later.
   initial begin
      for (int a = 0; a < (1 << AW); a++) mem_env[a] = init_word(a);
      forever begin
         @(posedge clk);
         if (mem_en) begin
            mem_rdata <= mem_env[mem_addr];
            for (int b = 0; b < 4; b++)
               if (mem_we[b]) mem_env[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] sat(input int n, input int maxv);
      return (n > maxv) ? 32'(maxv) : 32'(n);
   endfunction

   // One arbitration cycle: predict grants from the rules, check the memory
   // side, then update the model and queue expected read responses.
   task automatic step(output bit gi, output bit gd);
      @(negedge clk);
      gi = 1'b0;
      gd = 1'b0;
      if (i_req && d_req) begin
         if (last_d) gi = 1'b1; else gd = 1'b1;
      end else if (i_req) gi = 1'b1;
      else if (d_req) gd = 1'b1;
      chk("i_gnt", 32'(i_gnt), 32'(gi));
      chk("d_gnt", 32'(d_gnt), 32'(gd));
      chk("mem_en", 32'(mem_en), 32'(gi | gd));
      chk("i_cnt", 32'(i_cnt), sat(ni, 65535));
      chk("d_cnt", 32'(d_cnt), sat(nd, 65535));
      if (gi) begin
         chk("mem_addr_i", 32'(mem_addr), 32'(i_addr));
         chk("mem_we_i", 32'(mem_we), 32'h0);
         iq.push_back('{cyc: 32'(cyc + 1), data: ref_mem[i_addr]});
         ni++;
      end
      if (gd) begin
         chk("mem_addr_d", 32'(mem_addr), 32'(d_addr));
         chk("mem_we_d", 32'(mem_we), d_we ? 32'(d_wmask) : 32'h0);
         chk("mem_wdata", mem_wdata, d_wdata);
         if (d_we) begin
            for (int b = 0; b < 4; b++)
               if (d_wmask[b]) ref_mem[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
         end else begin
            dq.push_back('{cyc: 32'(cyc + 1), data: ref_mem[d_addr]});
         end
         nd++;
      end
      if (!gi && !gd) chk("mem_we_idle", 32'(mem_we), 32'h0);
      if (gi || gd) last_d = gd;
      @(posedge clk);
      #1;
   endtask

   // Response monitor: each rvalid must match the oldest expected response
   // for its port in the very cycle it is due; rdata is zero otherwise.
   always @(negedge clk) begin
      if (reset) begin
         if (iq.size() > 0 && iq[0].cyc < 32'(cyc)) begin
            chk("i_rvalid_missed", 32'(0), 32'(1));
            void'(iq.pop_front());
         end
         if (iq.size() > 0 && iq[0].cyc == 32'(cyc)) begin
            chk("i_rvalid", 32'(i_rvalid), 32'(1));
            chk("i_rdata", i_rdata, iq[0].data);
            void'(iq.pop_front());
         end else begin
            chk("i_rvalid_idle", 32'(i_rvalid), 32'(0));
            chk("i_rdata_idle", i_rdata, 32'h0);
         end
         if (dq.size() > 0 && dq[0].cyc < 32'(cyc)) begin
            chk("d_rvalid_missed", 32'(0), 32'(1));
            void'(dq.pop_front());
         end
         if (dq.size() > 0 && dq[0].cyc == 32'(cyc)) begin
            chk("d_rvalid", 32'(d_rvalid), 32'(1));
            chk("d_rdata", d_rdata, dq[0].data);
            void'(dq.pop_front());
         end else begin
            chk("d_rvalid_idle", 32'(d_rvalid), 32'(0));
            chk("d_rdata_idle", d_rdata, 32'h0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit gi, gd;
      for (int a = 0; a < (1 << AW); a++) ref_mem[a] = init_word(a);

      // reset state, with both ports requesting
      i_req = 1'b1;
      d_req = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_i_gnt", 32'(i_gnt), 32'(0));
      chk("rst_d_gnt", 32'(d_gnt), 32'(0));
      chk("rst_mem_en", 32'(mem_en), 32'(0));
      chk("rst_i_cnt", 32'(i_cnt), 32'(0));
      chk("rst_d_cnt", 32'(d_cnt), 32'(0));
      chk("rst_rvalid", 32'({i_rvalid, d_rvalid}), 32'(0));

      // single fetch of word 5
      d_req = 1'b0;
      i_addr = 8'd5;
      #1 reset = 1'b1;
      step(gi, gd);
      i_req = 1'b0;
      step(gi, gd);

      // contention from both ports, loads only
      i_req = 1'b1; i_addr = 8'd10;
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'd20;
      for (int k = 0; k < 4; k++) step(gi, gd);
      i_req = 1'b0; d_req = 1'b0;
      step(gi, gd);

      // partial store then load back
      d_req = 1'b1; d_we = 1'b1; d_addr = 8'd7; d_wmask = 4'b0011; d_wdata = 32'hAABB_CCDD;
      step(gi, gd);
      d_we = 1'b0;
      step(gi, gd);
      d_req = 1'b0;
      step(gi, gd);
      chk("store_merge", ref_mem[7], 32'h1122_CCDD);

      // zero-mask store leaves memory untouched
      d_req = 1'b1; d_we = 1'b1; d_addr = 8'd9; d_wmask = 4'b0000; d_wdata = 32'hDEAD_BEEF;
      step(gi, gd);
      d_we = 1'b0;
      step(gi, gd);
      d_req = 1'b0;
      step(gi, gd);

      // reset pulse with a read in flight
      i_req = 1'b1; i_addr = 8'd3;
      @(negedge clk);
      chk("pre_rst_i_gnt", 32'(i_gnt), 32'(1));
      #1 reset = 1'b0;
      #1;
      chk("rst2_gnt", 32'({i_gnt, d_gnt, mem_en}), 32'(0));
      chk("rst2_mem_we", 32'(mem_we), 32'(0));
      chk("rst2_rvalid", 32'({i_rvalid, d_rvalid}), 32'(0));
      chk("rst2_rdata", i_rdata | d_rdata, 32'h0);
      chk("rst2_cnt", 32'(i_cnt) | 32'(d_cnt), 32'(0));
      i_req = 1'b0;
      iq.delete(); dq.delete();
      ni = 0; nd = 0; last_d = 1'b0;
      #1 reset = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) step(gi, gd);

      // saturation of a 2-bit counter
      i_req2 = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         chk("i_cnt2_sat", 32'(i_cnt2), sat(k, 3));
      end
      i_req2 = 1'b0;

      // randomized traffic; a port holds its request until granted
      gi = 1'b0; gd = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!i_req || gi) begin
            i_req  = ($urandom_range(0, 3) != 0);
            i_addr = AW'($urandom);
         end
         if (!d_req || gd) begin
            d_req   = ($urandom_range(0, 3) != 0);
            d_we    = ($urandom_range(0, 2) == 0);
            d_addr  = AW'($urandom_range(0, 15));
            d_wmask = 4'($urandom);
            d_wdata = $urandom;
         end
         step(gi, gd);
      end
      i_req = 1'b0; d_req = 1'b0;
      for (int k = 0; k < 3; k++) step(gi, gd);
      chk("iq_drained", 32'(iq.size()), 32'(0));
      chk("dq_drained", 32'(dq.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 8, meaning word-address width (256 words).
REQ-002 The block SHALL have parameter CW, default 16, meaning grant-counter width.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port i_req, input, 1, instruction-fetch request.
REQ-006 The block SHALL have port i_addr, input, AW, instruction word address.
REQ-007 The block SHALL have port i_gnt, output, 1, fetch request accepted this cycle.
REQ-008 The block SHALL have port i_rvalid, output, 1, i_rdata valid.
REQ-009 The block SHALL have port i_rdata, output, 32, fetched word.
REQ-010 The block SHALL have port d_req, input, 1, data (load/store) request.
REQ-011 The block SHALL have port d_we, input, 1, 1 = store, 0 = load.
REQ-012 The block SHALL have port d_wmask, input, 4, byte enables for a store.
REQ-013 The block SHALL have port d_addr, input, AW, data word address.
REQ-014 The block SHALL have port d_wdata, input, 32, store data.
REQ-015 The block SHALL have ports d_gnt (output, 1), d_rvalid (output, 1) and d_rdata (output, 32), with the same meanings as the i_* equivalents.
REQ-016 The block SHALL have port mem_en, output, 1, memory access strobe.
REQ-017 The block SHALL have port mem_we, output, 4, per-byte memory write enable.
REQ-018 The block SHALL have port mem_addr, output, AW, memory word address.
REQ-019 The block SHALL have port mem_wdata, output, 32, memory write data.
REQ-020 The block SHALL have port mem_rdata, input, 32, memory read data, valid one cycle after a read strobe.
REQ-021 The block SHALL have ports i_cnt and d_cnt, output, CW each, grant counters.

Function
REQ-022 Each request SHALL be a level: the requester holds req, addr, we, wmask and wdata stable until it sees gnt=1 in a cycle, then deasserts or presents a new request.
REQ-023 Grant is combinational from the requests and registered state: at most one of i_gnt/d_gnt is high per cycle, and mem_en = i_gnt | d_gnt.
REQ-024 With a single requester, that requester SHALL be granted in the same cycle; the arbiter accepts one access per cycle.
REQ-025 With both requesting, the port not granted most recently SHALL win (round-robin); register last_owner updates on every grant.
REQ-026 On i_gnt: mem_addr=i_addr, mem_we=0. On d_gnt: mem_addr=d_addr, mem_we=d_we ? d_wmask : 0, mem_wdata=d_wdata.
REQ-027 With no grant: mem_en=0 and mem_we=0; mem_addr and mem_wdata are don't-care.
REQ-028 Read pipeline: a read grant SHALL set rd_pend=1 and rd_owner for the next cycle. That cycle pulses the owner's rvalid for exactly one cycle, with rdata=mem_rdata; the other port's rvalid stays 0.
REQ-029 Back-to-back reads SHALL be supported: a new grant is allowed in the same cycle as a prior read's rvalid, giving a throughput of 1 per cycle.
REQ-030 A store SHALL complete in its grant cycle and SHALL produce no rvalid; d_we=1 with d_wmask=0 is granted, writes nothing and produces no rvalid.
REQ-031 i_rdata/d_rdata SHALL equal mem_rdata only when the respective rvalid is high; otherwise both are 0.
REQ-032 i_cnt/d_cnt SHALL increment on each i_gnt/d_gnt and saturate at 2^CW-1 (no wrap).
REQ-033 Addresses are word addresses; no range check is performed, so wrap-around is the memory's concern.

Reset
REQ-034 While reset=0, asynchronously: i_gnt=d_gnt=0, mem_en=0, mem_we=0, rd_pend=0, i_rvalid=d_rvalid=0, i_cnt=d_cnt=0, last_owner=I (so data wins the first contention).
REQ-035 Reset asserted with a read in flight SHALL drop it; no rvalid is issued after release.
REQ-036 The first grant is possible in the first clock edge after reset deasserts.

Verification
REQ-037 Only i_req=1, i_addr=5, mem[5]=0x00000013 -> i_gnt=1, mem_en=1, mem_addr=5 in cycle 0; i_rvalid=1 with i_rdata=0x00000013 in cycle 1; i_cnt=1.
REQ-038 Both request continuously from reset (loads) -> grant order D,I,D,I over 4 cycles; rvalid follows each grant by 1 cycle to the matching port; i_cnt=d_cnt=2.
REQ-039 d_req store, d_addr=7, d_wmask=0b0011, d_wdata=0xAABBCCDD over mem[7]=0x11223344 -> mem_we=0011; a subsequent load of 7 returns 0x1122CCDD; no d_rvalid for the store.
REQ-040 Store with d_wmask=0 -> d_gnt=1, mem_we=0, memory unchanged, d_cnt increments.
REQ-041 Read granted, then reset pulsed low before the next edge -> no rvalid, all outputs 0, counters 0.
REQ-042 CW=2 with 5 consecutive i grants -> i_cnt reads 1,2,3,3,3.
